// File: rtl/enemy_hit_detect_if.sv
// Bullet bus between the bullet state machine (master) and an enemy hit detector (slave):
// bullet positions and in-flight flags one way, per-bullet hit pulses back.
interface enemy_hit_detect_if;
  logic [9:0] sprite12xr;
  logic [9:0] sprite12yr;
  logic       is_shot_1;
  logic [9:0] sprite13xr;
  logic [9:0] sprite13yr;
  logic       is_shot_2;
  logic       bullet1_hit;
  logic       bullet2_hit;

  modport master (
    output sprite12xr, sprite12yr, is_shot_1,
    output sprite13xr, sprite13yr, is_shot_2,
    input  bullet1_hit, bullet2_hit
  );

  modport slave (
    input  sprite12xr, sprite12yr, is_shot_1,
    input  sprite13xr, sprite13yr, is_shot_2,
    output bullet1_hit, bullet2_hit
  );
endinterface

// File: rtl/enemy_hit_detect.sv
// Per-frame enemy hit detection: tests two bullets against one enemy hitbox and tracks
// health, invulnerability frames, death animation, respawn and a saturating kill count.
module enemy_hit_detect #(
  parameter int unsigned ENEMY_W      = 32,
  parameter int unsigned ENEMY_H      = 32,
  parameter int unsigned BULLET_W     = 8,
  parameter int unsigned BULLET_H     = 8,
  parameter int unsigned MAX_HP       = 4,
  parameter int unsigned IFRAMES      = 8,
  parameter int unsigned DEATH_FRAMES = 16,
  parameter int unsigned FLASH_SHIFT  = 1
) (
  input  logic                 frame_clk,
  input  logic                 Reset,
  enemy_hit_detect_if.slave    bullets,
  input  logic [9:0]           enemy_x,
  input  logic [9:0]           enemy_y,
  input  logic                 enemy_spawn,
  output logic                 kill_pulse,
  output logic                 enemy_alive,
  output logic                 enemy_visible,
  output logic [3:0]           enemy_health,
  output logic [7:0]           kill_count
);

  typedef enum logic [1:0] {
    DEAD  = 2'd0,
    ALIVE = 2'd1,
    HURT  = 2'd2,
    DYING = 2'd3
  } state_t;

  state_t     state, state_n;
  logic [4:0] cnt, cnt_n;
  logic [3:0] health_n;
  logic [7:0] kills_n;
  logic       hit1_q, hit2_q;
  logic       hit1_n, hit2_n, kill_n, alive_n, visible_n;
  logic       ov1, ov2;

  // Widened to 11 bits so edge + size cannot wrap near the 10-bit limit.
  function automatic logic overlap(input logic [9:0] bx, input logic [9:0] by,
                                   input logic [9:0] ex, input logic [9:0] ey,
                                   input logic shot);
    logic [10:0] bxw, byw, exw, eyw;
    bxw = {1'b0, bx};
    byw = {1'b0, by};
    exw = {1'b0, ex};
    eyw = {1'b0, ey};
    return shot
        && (bxw < exw + 11'(ENEMY_W)) && (exw < bxw + 11'(BULLET_W))
        && (byw < eyw + 11'(ENEMY_H)) && (eyw < byw + 11'(BULLET_H));
  endfunction

  assign ov1 = overlap(bullets.sprite12xr, bullets.sprite12yr, enemy_x, enemy_y, bullets.is_shot_1);
  assign ov2 = overlap(bullets.sprite13xr, bullets.sprite13yr, enemy_x, enemy_y, bullets.is_shot_2);

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    health_n  = enemy_health;
    kills_n   = kill_count;
    hit1_n    = 1'b0;
    hit2_n    = 1'b0;
    kill_n    = 1'b0;
    alive_n   = 1'b0;
    visible_n = 1'b0;

    unique case (state)
      DEAD: begin
        health_n = '0;
        cnt_n    = '0;
        if (enemy_spawn) begin
          state_n  = ALIVE;
          health_n = 4'(MAX_HP);
        end
      end
      ALIVE: begin
        if (ov1 || ov2) begin
          hit1_n   = ov1;
          hit2_n   = ov2;
          health_n = enemy_health - 4'd1;
          if (enemy_health == 4'd1) begin
            kill_n  = 1'b1;
            kills_n = (kill_count == '1) ? kill_count : kill_count + 8'd1;
            cnt_n   = 5'(DEATH_FRAMES - 1);
            state_n = DYING;
          end else begin
            cnt_n   = 5'(IFRAMES - 1);
            state_n = HURT;
          end
        end
      end
      HURT: begin
        if (cnt == '0) state_n = ALIVE;
        else           cnt_n   = cnt - 5'd1;
      end
      DYING: begin
        if (cnt == '0) state_n = DEAD;
        else           cnt_n   = cnt - 5'd1;
      end
      default: state_n = DEAD;
    endcase

    // Outputs are registered, so they are derived from the state being entered.
    unique case (state_n)
      ALIVE: begin
        alive_n   = 1'b1;
        visible_n = 1'b1;
      end
      HURT: begin
        alive_n   = 1'b1;
        visible_n = ~cnt_n[FLASH_SHIFT];
      end
      DYING:   visible_n = ~cnt_n[FLASH_SHIFT];
      default: visible_n = 1'b0;
    endcase
  end

  always_ff @(posedge frame_clk) begin
    if (!Reset) begin
      state         <= DEAD;
      cnt           <= '0;
      enemy_health  <= '0;
      kill_count    <= '0;
      hit1_q        <= 1'b0;
      hit2_q        <= 1'b0;
      kill_pulse    <= 1'b0;
      enemy_alive   <= 1'b0;
      enemy_visible <= 1'b0;
    end else begin
      state         <= state_n;
      cnt           <= cnt_n;
      enemy_health  <= health_n;
      kill_count    <= kills_n;
      hit1_q        <= hit1_n;
      hit2_q        <= hit2_n;
      kill_pulse    <= kill_n;
      enemy_alive   <= alive_n;
      enemy_visible <= visible_n;
    end
  end

  assign bullets.bullet1_hit = hit1_q;
  assign bullets.bullet2_hit = hit2_q;

endmodule

// File: tb/tb_enemy_hit_detect.sv
// Scoreboard bench for enemy_hit_detect: a frame-level reference model pushes expected
// outputs as stimulus is driven; they are popped and compared one frame later.
module tb_enemy_hit_detect;

  logic       frame_clk = 1'b0;
  logic       Reset     = 1'b0;
  logic [9:0] enemy_x, enemy_y;
  logic       enemy_spawn;
  logic       kill_pulse, enemy_alive, enemy_visible;
  logic [3:0] enemy_health;
  logic [7:0] kill_count;

  enemy_hit_detect_if bif ();

  enemy_hit_detect #(
    .ENEMY_W(32), .ENEMY_H(32), .BULLET_W(8), .BULLET_H(8),
    .MAX_HP(4), .IFRAMES(8), .DEATH_FRAMES(16), .FLASH_SHIFT(1)
  ) dut (
    .frame_clk     (frame_clk),
    .Reset         (Reset),
    .bullets       (bif),
    .enemy_x       (enemy_x),
    .enemy_y       (enemy_y),
    .enemy_spawn   (enemy_spawn),
    .kill_pulse    (kill_pulse),
    .enemy_alive   (enemy_alive),
    .enemy_visible (enemy_visible),
    .enemy_health  (enemy_health),
    .kill_count    (kill_count)
  );

  always #5 frame_clk = ~frame_clk;

  typedef struct packed {
    logic       h1, h2, kp, alive, vis;
    logic [3:0] hp;
    logic [7:0] kc;
  } exp_t;

  typedef enum {M_DEAD, M_ALIVE, M_HURT, M_DYING} mst_t;

  exp_t sb[$];
  mst_t m_st  = M_DEAD;
  int   m_cnt = 0;
  int   m_hp  = 0;
  int   m_kc  = 0;
  int   checks   = 0;
  int   failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  function automatic bit hits(input int bx, input int by, input bit shot);
    int ex, ey;
    ex = int'(enemy_x);
    ey = int'(enemy_y);
    return shot && (bx < ex + 32) && (ex < bx + 8) && (by < ey + 32) && (ey < by + 8);
  endfunction

  task automatic step();
    exp_t e;
    exp_t g;
    bit   o1, o2;
    e  = '0;
    o1 = hits(int'(bif.sprite12xr), int'(bif.sprite12yr), bif.is_shot_1);
    o2 = hits(int'(bif.sprite13xr), int'(bif.sprite13yr), bif.is_shot_2);
    if (!Reset) begin
      m_st = M_DEAD; m_cnt = 0; m_hp = 0; m_kc = 0;
    end else begin
      case (m_st)
        M_DEAD: if (enemy_spawn) begin m_st = M_ALIVE; m_hp = 4; end
        M_ALIVE: if (o1 || o2) begin
          e.h1 = o1;
          e.h2 = o2;
          m_hp = m_hp - 1;
          if (m_hp == 0) begin
            e.kp = 1'b1;
            if (m_kc < 255) m_kc = m_kc + 1;
            m_cnt = 15;
            m_st  = M_DYING;
          end else begin
            m_cnt = 7;
            m_st  = M_HURT;
          end
        end
        M_HURT:  if (m_cnt == 0) m_st = M_ALIVE; else m_cnt = m_cnt - 1;
        M_DYING: if (m_cnt == 0) m_st = M_DEAD;  else m_cnt = m_cnt - 1;
      endcase
    end
    e.alive = (m_st == M_ALIVE) || (m_st == M_HURT);
    if (m_st == M_ALIVE)                         e.vis = 1'b1;
    else if (m_st == M_HURT || m_st == M_DYING)  e.vis = ((m_cnt / 2) % 2) == 0;
    else                                         e.vis = 1'b0;
    e.hp = 4'(m_hp);
    e.kc = 8'(m_kc);
    sb.push_back(e);

    @(posedge frame_clk);
    #1;
    g = sb.pop_front();
    check("bullet1_hit",   bif.bullet1_hit, g.h1);
    check("bullet2_hit",   bif.bullet2_hit, g.h2);
    check("kill_pulse",    kill_pulse,      g.kp);
    check("enemy_alive",   enemy_alive,     g.alive);
    check("enemy_visible", enemy_visible,   g.vis);
    check("enemy_health",  enemy_health,    g.hp);
    check("kill_count",    kill_count,      g.kc);
  endtask

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic set_b1(input int x, input int y, input bit shot);
    bif.sprite12xr = 10'(x);
    bif.sprite12yr = 10'(y);
    bif.is_shot_1  = shot;
  endtask

  task automatic set_b2(input int x, input int y, input bit shot);
    bif.sprite13xr = 10'(x);
    bif.sprite13yr = 10'(y);
    bif.is_shot_2  = shot;
  endtask

  initial begin
    enemy_x = 10'd100;
    enemy_y = 10'd100;
    enemy_spawn = 1'b0;
    set_b1(0, 0, 1'b0);
    set_b2(0, 0, 1'b0);

    // Reset
    Reset = 1'b0;
    frames(2);
    check("rst_health",  enemy_health,  0);
    check("rst_visible", enemy_visible, 0);
    check("rst_kills",   kill_count,    0);

    // Spawn with an overlapping bullet in the same frame: no damage yet
    Reset = 1'b1;
    enemy_spawn = 1'b1;
    set_b1(110, 110, 1'b1);
    step();
    check("spawn_no_dmg", enemy_health, 4);
    enemy_spawn = 1'b0;
    step();
    check("t2_hit1", bif.bullet1_hit, 1);
    check("t2_hp", enemy_health, 3);
    check("t2_hurt_vis", enemy_visible, 0);
    set_b1(0, 0, 1'b0);
    frames(8);
    check("t2_alive_vis", enemy_visible, 1);

    // Spawn request outside DEAD is ignored
    enemy_spawn = 1'b1;
    step();
    enemy_spawn = 1'b0;
    check("spawn_ignored", enemy_health, 3);

    // Both bullets in the same frame: one point of damage
    set_b1(110, 110, 1'b1);
    set_b2(120, 120, 1'b1);
    step();
    check("t3_hit1", bif.bullet1_hit, 1);
    check("t3_hit2", bif.bullet2_hit, 1);
    check("t3_hp", enemy_health, 2);
    set_b1(0, 0, 1'b0);
    set_b2(0, 0, 1'b0);
    frames(8);

    // Bullet held on the enemy through HURT
    set_b1(110, 110, 1'b1);
    step();
    frames(8);
    check("t4_hp", enemy_health, 1);
    set_b1(0, 0, 1'b0);
    frames(2);

    // Hitbox boundaries
    set_b1(132, 110, 1'b1); step(); check("x132_miss", bif.bullet1_hit, 0);
    set_b1(92, 110, 1'b1);  step(); check("x92_miss",  bif.bullet1_hit, 0);
    set_b1(110, 110, 1'b0); step(); check("noshot_miss", bif.bullet1_hit, 0);
    set_b1(131, 110, 1'b1); step();
    check("x131_hit", bif.bullet1_hit, 1);
    check("kill_pulse_hi", kill_pulse, 1);
    check("kill_count1", kill_count, 1);
    set_b1(0, 0, 1'b0);
    step();
    check("kill_pulse_lo", kill_pulse, 0);
    frames(15);
    check("dead_alive", enemy_alive, 0);

    enemy_spawn = 1'b1;
    step();
    enemy_spawn = 1'b0;
    set_b1(93, 110, 1'b1);
    step();
    check("x93_hit", bif.bullet1_hit, 1);
    set_b1(0, 0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      frames(8);
      set_b2(105, 130, 1'b1);
      step();
      set_b2(0, 0, 1'b0);
    end
    check("kill_count2", kill_count, 2);

    // Reset in the middle of the death animation
    frames(5);
    Reset = 1'b0;
    step();
    check("midrst_kills", kill_count, 0);
    check("midrst_vis", enemy_visible, 0);
    Reset = 1'b1;
    frames(3);

    // Continuous spawn and fire until kill_count saturates
    enemy_spawn = 1'b1;
    set_b1(110, 110, 1'b1);
    frames(11700);
    check("kill_sat", kill_count, 255);
    enemy_spawn = 1'b0;
    set_b1(0, 0, 1'b0);
    frames(20);

    check("sb_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
